// File: rtl/regfile_seq.sv
// Command-driven port sequencer for the 8x8 register file: single writes and full-file dumps.
// Define REGFILE_SEQ_CLEAR_EN to zero every register after each reset.
module regfile_seq #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_data,
    output logic [AW-1:0]   wa,
    output logic [DW-1:0]   wd,
    output logic            we,
    output logic [AW-1:0]   ra1,
    output logic [AW-1:0]   ra2,
    input  logic [DW-1:0]   rd1,
    input  logic [DW-1:0]   rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE, S_DUMP} state_t;

    localparam logic [AW-1:0] LAST = '1;

`ifdef REGFILE_SEQ_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [AW-1:0] idx_inc;
    logic          we_reg, we_next;
    logic [AW-1:0] wa_reg, wa_next;
    logic [DW-1:0] wd_reg, wd_next;
    logic [AW-1:0] ra1_reg, ra1_next;
    logic [AW-1:0] ra2_reg, ra2_next;
    logic          cmd_ready_reg, cmd_ready_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_last_reg, out_last_next;
    logic          busy_reg, busy_next;

    assign idx_inc = idx_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RESET_STATE;
            idx_reg       <= '0;
            we_reg        <= 1'b0;
            wa_reg        <= '0;
            wd_reg        <= '0;
            ra1_reg       <= '0;
            ra2_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            we_reg        <= we_next;
            wa_reg        <= wa_next;
            wd_reg        <= wd_next;
            ra1_reg       <= ra1_next;
            ra2_reg       <= ra2_next;
            cmd_ready_reg <= cmd_ready_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state logic also computes every registered output for the coming cycle.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        we_next        = 1'b0;
        wa_next        = wa_reg;
        wd_next        = wd_reg;
        ra1_next       = ra1_reg;
        ra2_next       = ra2_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        case (state_reg)
            S_CLEAR: begin
                // The last clear write is visible on the port before we leave.
                if (we_reg && wa_reg == LAST) begin
                    state_next = S_IDLE;
                end else begin
                    we_next = 1'b1;
                    wa_next = we_reg ? wa_reg + 1'b1 : '0;
                    wd_next = '0;
                end
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    if (cmd_op) begin
                        state_next     = S_DUMP;
                        idx_next       = '0;
                        ra1_next       = '0;
                        ra2_next       = LAST;
                        out_valid_next = 1'b1;
                        out_last_next  = 1'b0;
                    end else begin
                        state_next = S_WRITE;
                        we_next    = 1'b1;
                        wa_next    = cmd_addr;
                        wd_next    = cmd_data;
                    end
                end
            end
            S_WRITE: begin
                state_next = S_IDLE;
            end
            S_DUMP: begin
                if (out_ready) begin
                    if (idx_reg == LAST) begin
                        state_next     = S_IDLE;
                        idx_next       = '0;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                    end else begin
                        idx_next      = idx_inc;
                        ra1_next      = idx_inc;
                        ra2_next      = LAST - idx_inc;
                        out_last_next = (idx_inc == LAST);
                    end
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
        cmd_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next != S_IDLE);
    end

    assign we        = we_reg;
    assign wa        = wa_reg;
    assign wd        = wd_reg;
    assign ra1       = ra1_reg;
    assign ra2       = ra2_reg;
    assign cmd_ready = cmd_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign out_data  = {rd1, rd2};

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 8x8 register file on its ports.
// Expectations follow REGFILE_SEQ_CLEAR_EN when the macro is defined.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic        we;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [8];
    logic [7:0] exp_mem [8];

    always #5 clk = ~clk;

    regfile_seq #(.DW(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .wa(wa), .wd(wd), .we(we),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    // Register file attached to the sequencer ports.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic after_release();
`ifdef REGFILE_SEQ_CLEAR_EN
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("clr_port", {we, wa, wd}, {1'b1, 3'(k), 8'h00});
            chk("clr_ready", {31'b0, cmd_ready}, 32'd0);
            exp_mem[k] = 8'h00;
        end
        @(posedge clk); #1;
        chk("clr_done", {we, cmd_ready, busy}, 3'b010);
        $display("clear sequence observed");
`else
        @(posedge clk); #1;
        chk("rel_ready", {we, cmd_ready, busy}, 3'b010);
        $display("release to idle observed");
`endif
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = a;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("wr_port", {we, wa, wd}, {1'b1, a, d});
        chk("wr_busy", {cmd_ready, busy}, 2'b01);
        exp_mem[a] = d;
        @(posedge clk); #1;
        chk("wr_done", {we, cmd_ready, busy}, 3'b010);
        $display("write a=%0d d=%h", a, d);
    endtask

    // mode 0: sink always ready; mode 1: ready pattern 1,0,0 repeating.
    task automatic do_dump(input int mode, input bit hold_wr);
        logic [15:0] exp_d;
        int beat = 0;
        int cyc = 0;
        wait_ready();
        cmd_op    = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (hold_wr) begin
            cmd_valid = 1'b1;
            cmd_op    = 1'b0;
            cmd_addr  = 3'd3;
            cmd_data  = 8'hA5;
        end
        while (beat < 8 && cyc < 64) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            exp_d = {exp_mem[beat], exp_mem[7 - beat]};
            chk("dump_valid", {31'b0, out_valid}, 32'd1);
            chk("dump_data", {16'b0, out_data}, {16'b0, exp_d});
            chk("dump_ra", {ra1, ra2}, {beat[2:0], 3'(7 - beat)});
            chk("dump_last", {31'b0, out_last}, {31'b0, beat == 7});
            chk("dump_cmd_ready", {we, cmd_ready, busy}, 3'b001);
            if (out_ready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("dump_beats", beat, 32'd8);
        chk("dump_end", {out_valid, out_last, cmd_ready}, 3'b001);
        if (mode == 0) chk("dump_cycles", cyc, 32'd8);
        $display("dump mode=%0d beats=%0d cycles=%0d", mode, beat, cyc);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) exp_mem[k] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ports", {we, wa, wd, ra1, ra2}, 20'h0);
        chk("rst_flags", {cmd_ready, out_valid, out_last, busy}, 4'b0001);
        $display("reset state checked");
        rst = 1'b0;
        after_release();

`ifdef REGFILE_SEQ_CLEAR_EN
        do_dump(0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'h80 + 8'(i));
        do_dump(0, 1'b0);
        do_dump(1, 1'b0);

        // A write held during a dump must wait for the dump to end.
        do_dump(0, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("held_wr_port", {we, wa, wd}, {1'b1, 3'd3, 8'hA5});
        exp_mem[3] = 8'hA5;
        @(posedge clk); #1;
        chk("held_wr_done", {we, cmd_ready}, 2'b01);
        $display("held write a=3 d=a5");
        do_dump(0, 1'b0);

        do_write(3'd7, 8'h3C);
        do_dump(0, 1'b0);

        // Reset while the fourth beat is on the output.
        wait_ready();
        cmd_op    = 1'b1;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_beat4", {out_valid, ra1, ra2}, {1'b1, 3'd3, 3'd4});
        rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("mid_rst", {out_valid, out_last, busy, cmd_ready, we}, 5'b00100);
        $display("reset during dump checked");
        rst = 1'b0;
        after_release();
        do_dump(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
